// File: rtl/d_latch_out_monitor.sv
// D-latch output monitor: synchronizes q/qb, glitch-filters q into a
// debounced level with rise/fall strobes, a transition count and a q/qb check.
module d_latch_out_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q,
  input  logic             qb,
  input  logic             clr_cnt,
  input  logic             mismatch_clr,
  output logic             q_stable,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat,
  output logic             mismatch
);

  localparam int FW = $clog2(FILT_LEN) + 1;
  localparam logic [FW-1:0] FLEN = FW'(FILT_LEN);

  typedef enum logic [1:0] {
    LO,
    CHK_HI,
    HI,
    CHK_LO
  } state_t;

  logic [SYNC_STAGES-1:0] q_sync;
  logic [SYNC_STAGES-1:0] qb_sync;
  logic                   q_s;
  logic                   qb_s;

  state_t        state;
  state_t        state_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;
  logic [FW-1:0] fcnt_inc;
  logic          rise_n;
  logic          fall_n;
  logic          pulse;
  logic          eq;
  logic          eq_d;
  logic          mm_set;

  // Chains reset to the complementary idle pair so reset never looks like a mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync  <= '0;
      qb_sync <= '1;
    end else begin
      q_sync  <= {q_sync[SYNC_STAGES-2:0], q};
      qb_sync <= {qb_sync[SYNC_STAGES-2:0], qb};
    end
  end

  assign q_s  = q_sync[SYNC_STAGES-1];
  assign qb_s = qb_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LO;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    fcnt_inc = fcnt + 1'b1;
    unique case (state)
      LO: begin
        if (q_s) begin
          if (FILT_LEN == 1) begin
            state_n = HI;
            fcnt_n  = '0;
          end else begin
            state_n = CHK_HI;
            fcnt_n  = FW'(1);
          end
        end
      end
      CHK_HI: begin
        if (!q_s) begin
          state_n = LO;
          fcnt_n  = '0;
        end else if (fcnt_inc == FLEN) begin
          state_n = HI;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt_inc;
        end
      end
      HI: begin
        if (!q_s) begin
          if (FILT_LEN == 1) begin
            state_n = LO;
            fcnt_n  = '0;
          end else begin
            state_n = CHK_LO;
            fcnt_n  = FW'(1);
          end
        end
      end
      CHK_LO: begin
        if (q_s) begin
          state_n = HI;
          fcnt_n  = '0;
        end else if (fcnt_inc == FLEN) begin
          state_n = LO;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt_inc;
        end
      end
    endcase
  end

  assign q_stable = (state == HI) || (state == CHK_LO);

  assign rise_n = (state_n == HI) &&
                  ((state == LO) || (state == CHK_HI));
  assign fall_n = (state_n == LO) &&
                  ((state == HI) || (state == CHK_LO));
  assign pulse  = rise_n | fall_n;

  // Count lands on the same edge that raises the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      rise <= rise_n;
      fall <= fall_n;
      if (clr_cnt) begin
        edge_cnt <= pulse ? CNT_W'(1) : '0;
      end else if (pulse && !cnt_sat) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  assign cnt_sat = &edge_cnt;

  assign eq     = (q_s == qb_s);
  assign mm_set = eq && eq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_d     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      eq_d <= eq;
      if (mm_set) begin
        mismatch <= 1'b1;
      end else if (mismatch_clr) begin
        mismatch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_d_latch_out_monitor.sv
// Bench for d_latch_out_monitor: three instances (defaults, CNT_W=2,
// FILT_LEN=1); strobes are matched against a queue of expected events.
module tb_d_latch_out_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2:0] rst;
  logic [2:0] q;
  logic [2:0] qb;
  logic [2:0] clr;
  logic [2:0] mclr;
  logic [2:0] qs;
  logic [2:0] ri;
  logic [2:0] fa;
  logic [2:0] sat;
  logic [2:0] mm;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_c;

  d_latch_out_monitor u_a (
    .clk(clk), .rst(rst[0]), .q(q[0]), .qb(qb[0]),
    .clr_cnt(clr[0]), .mismatch_clr(mclr[0]),
    .q_stable(qs[0]), .rise(ri[0]), .fall(fa[0]),
    .edge_cnt(cnt_a), .cnt_sat(sat[0]), .mismatch(mm[0])
  );

  d_latch_out_monitor #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst[1]), .q(q[1]), .qb(qb[1]),
    .clr_cnt(clr[1]), .mismatch_clr(mclr[1]),
    .q_stable(qs[1]), .rise(ri[1]), .fall(fa[1]),
    .edge_cnt(cnt_b), .cnt_sat(sat[1]), .mismatch(mm[1])
  );

  d_latch_out_monitor #(.FILT_LEN(1)) u_c (
    .clk(clk), .rst(rst[2]), .q(q[2]), .qb(qb[2]),
    .clr_cnt(clr[2]), .mismatch_clr(mclr[2]),
    .q_stable(qs[2]), .rise(ri[2]), .fall(fa[2]),
    .edge_cnt(cnt_c), .cnt_sat(sat[2]), .mismatch(mm[2])
  );

  typedef struct {
    int   dut;
    logic kind;
    int   cnt;
    int   at;
  } exp_t;

  exp_t sbq[$];
  int   cm[3];
  int   mx[3] = '{255, 3, 255};

  task automatic chk(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic k, input int lat);
    cm[d] = (cm[d] < mx[d]) ? cm[d] + 1 : cm[d];
    sbq.push_back('{d, k, cm[d], cyc + lat});
  endtask

  task automatic mon(input int d, input logic r, input logic f,
                     input int cnt, input logic s, input int mxv);
    exp_t e;
    if (r || f) begin
      chk("no_overlap", int'(r & f), 0);
      chk("sb_nonempty", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("strobe_dut", d, e.dut);
        chk("strobe_kind", int'(r), int'(e.kind));
        chk("strobe_cnt", cnt, e.cnt);
        chk("strobe_cyc", cyc, e.at);
        chk("strobe_sat", int'(s), int'(e.cnt == mxv));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ri[0], fa[0], int'(cnt_a), sat[0], mx[0]);
    mon(1, ri[1], fa[1], int'(cnt_b), sat[1], mx[1]);
    mon(2, ri[2], fa[2], int'(cnt_c), sat[2], mx[2]);
  end

  initial begin
    rst  = '1;
    q    = '0;
    qb   = '1;
    clr  = '0;
    mclr = '0;
    cm   = '{0, 0, 0};
    tick(1);

    // reset with q high
    q[0] = 1'b1;
    qb[0] = 1'b0;
    tick(3);
    chk("rst_qs", int'(qs[0]), 0);
    chk("rst_rise", int'(ri[0]), 0);
    chk("rst_fall", int'(fa[0]), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_sat", int'(sat[0]), 0);
    chk("rst_mm", int'(mm[0]), 0);
    rst[0] = 1'b0;
    push(0, 1'b1, 6);
    tick(5);
    chk("pre_rise_qs", int'(qs[0]), 0);
    tick(1);
    chk("rise_qs", int'(qs[0]), 1);
    chk("rise_hi", int'(ri[0]), 1);
    chk("rise_cnt", int'(cnt_a), 1);
    tick(1);
    chk("rise_width", int'(ri[0]), 0);

    // glitch rejection
    rst[0] = 1'b1;
    q[0] = 1'b0;
    qb[0] = 1'b1;
    tick(2);
    rst[0] = 1'b0;
    cm[0] = 0;
    tick(8);
    chk("glitch_pre_cnt", int'(cnt_a), 0);
    q[0] = 1'b1;
    qb[0] = 1'b0;
    tick(3);
    q[0] = 1'b0;
    qb[0] = 1'b1;
    tick(10);
    chk("glitch_qs", int'(qs[0]), 0);
    chk("glitch_cnt", int'(cnt_a), 0);
    chk("glitch_mm", int'(mm[0]), 0);

    // pulse of exactly FILT_LEN is accepted
    q[0] = 1'b1;
    qb[0] = 1'b0;
    push(0, 1'b1, 6);
    tick(4);
    q[0] = 1'b0;
    qb[0] = 1'b1;
    push(0, 1'b0, 6);
    tick(8);
    chk("exact_cnt", int'(cnt_a), 2);
    chk("exact_qs", int'(qs[0]), 0);

    // mismatch
    q[0] = 1'b1;
    qb[0] = 1'b0;
    push(0, 1'b1, 6);
    tick(8);
    qb[0] = 1'b1;
    tick(1);
    qb[0] = 1'b0;
    tick(6);
    chk("mm_one_cycle", int'(mm[0]), 0);
    qb[0] = 1'b1;
    tick(3);
    chk("mm_lat_lo", int'(mm[0]), 0);
    tick(1);
    chk("mm_set", int'(mm[0]), 1);
    qb[0] = 1'b0;
    tick(6);
    chk("mm_sticky", int'(mm[0]), 1);
    qb[0] = 1'b1;
    tick(4);
    mclr[0] = 1'b1;
    tick(1);
    mclr[0] = 1'b0;
    chk("mm_set_wins", int'(mm[0]), 1);
    qb[0] = 1'b0;
    tick(4);
    mclr[0] = 1'b1;
    tick(1);
    mclr[0] = 1'b0;
    chk("mm_cleared", int'(mm[0]), 0);

    // reset in the middle of CHK_HI
    q[0] = 1'b0;
    qb[0] = 1'b1;
    push(0, 1'b0, 6);
    tick(8);
    q[0] = 1'b1;
    qb[0] = 1'b0;
    tick(4);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    cm[0] = 0;
    chk("midrst_qs", int'(qs[0]), 0);
    chk("midrst_rise", int'(ri[0]), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    push(0, 1'b1, 6);
    tick(5);
    chk("midrst_pre_qs", int'(qs[0]), 0);
    tick(1);
    chk("midrst_qs_hi", int'(qs[0]), 1);

    // saturation with CNT_W=2
    rst[1] = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      q[1] = !q[1];
      qb[1] = !q[1];
      push(1, q[1], 6);
      tick(8);
    end
    chk("sat_cnt", int'(cnt_b), 3);
    chk("sat_flag", int'(sat[1]), 1);
    q[1] = 1'b0;
    qb[1] = 1'b1;
    cm[1] = 0;
    push(1, 1'b0, 6);
    tick(5);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    chk("clr_coincide_cnt", int'(cnt_b), 1);
    chk("clr_coincide_sat", int'(sat[1]), 0);
    tick(2);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    cm[1] = 0;
    chk("clr_plain", int'(cnt_b), 0);

    // FILT_LEN=1
    rst[2] = 1'b0;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      q[2] = !q[2];
      qb[2] = !q[2];
      push(2, q[2], 3);
      tick(4);
    end
    tick(6);
    chk("f1_cnt", int'(cnt_c), 6);
    chk("f1_qs", int'(qs[2]), 0);

    tick(10);
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
